param_serializer: RTL and testbench

- Parallel-in, serial-out shifter; the transmit side paired with the team's N-bit parallel register.
- Accepts an N-bit word through a valid/ready load handshake and emits it one bit per accepted beat.
- The serial output has its own valid/ready handshake, with last-bit and done strobes.
- Feeds the downstream serial link and bit-serial datapath stages of the CPU.

---
 rtl/param_serializer.sv | 133 +++++++++++++
 tb/tb_param_serializer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/param_serializer.sv
// Parallel-in, serial-out shifter with valid/ready load and serial handshakes.
// A word is captured in IDLE, then emitted one bit per accepted beat in SHIFT.
// All outputs come straight from flops; the next-state logic is computed once
// and registered together with the decoded outputs.
module param_serializer #(
  parameter int N         = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] d_param,
  input  logic         load_valid,
  output logic         load_ready,
  output logic         q_serial,
  output logic         q_valid,
  input  logic         ser_ready,
  output logic         q_last,
  output logic         done
);

  localparam int            CW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]    state_r;
  logic [0:0]    state_s;
  logic [N-1:0]  shift_r;
  logic [N-1:0]  shift_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_s;
  logic          done_s;

  logic          load_ready_r;
  logic          q_serial_r;
  logic          q_valid_r;
  logic          q_last_r;
  logic          done_r;

  // Bit presented at the output end of a shift-register image.
  function automatic logic out_bit(input logic [N-1:0] v);
    logic b;
    if (MSB_FIRST != 0) begin
      b = v[N-1];
    end else begin
      b = v[0];
    end
    return b;
  endfunction

  // Shift one position toward the output end.
  function automatic logic [N-1:0] shift_once(input logic [N-1:0] v);
    logic [N-1:0] r;
    if (MSB_FIRST != 0) begin
      r = v << 1'b1;
    end else begin
      r = v >> 1'b1;
    end
    return r;
  endfunction

  // Next-state logic: load capture in IDLE, bit transfers in SHIFT.
  always_comb begin
    state_s = state_r;
    shift_s = shift_r;
    cnt_s   = cnt_r;
    done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // Gate with the registered ready so no word is taken in the
        // cycle right after reset, while load_ready is still low.
        if (load_valid && load_ready_r) begin
          state_s = ST_SHIFT;
          shift_s = d_param;
          cnt_s   = {CW{1'b0}};
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        // q_valid is always high in SHIFT, so ser_ready alone means transfer.
        if (ser_ready) begin
          shift_s = shift_once(shift_r);
          if (cnt_r == CNT_LAST) begin
            state_s = ST_IDLE;
            cnt_s   = {CW{1'b0}};
            done_s  = 1'b1;
          end else begin
            cnt_s   = cnt_r + 1'b1;
          end
        end else begin
          state_s = ST_SHIFT;
        end
      end
      default: begin
        state_s = ST_IDLE;
        shift_s = {N{1'b0}};
        cnt_s   = {CW{1'b0}};
      end
    endcase
  end

  // State and registered outputs, decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      shift_r      <= {N{1'b0}};
      cnt_r        <= {CW{1'b0}};
      load_ready_r <= 1'b0;
      q_serial_r   <= 1'b0;
      q_valid_r    <= 1'b0;
      q_last_r     <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      shift_r      <= shift_s;
      cnt_r        <= cnt_s;
      load_ready_r <= (state_s == ST_IDLE);
      q_valid_r    <= (state_s == ST_SHIFT);
      q_serial_r   <= (state_s == ST_SHIFT) & out_bit(shift_s);
      q_last_r     <= (state_s == ST_SHIFT) && (cnt_s == CNT_LAST);
      done_r       <= done_s;
    end
  end

  assign load_ready = load_ready_r;
  assign q_serial   = q_serial_r;
  assign q_valid    = q_valid_r;
  assign q_last     = q_last_r;
  assign done       = done_r;

endmodule

// File: tb/tb_param_serializer.sv
// Directed bench for param_serializer: LSB-first and MSB-first N=4 instances
// driven in parallel, plus an N=1 instance for the single-bit edge case.
module tb_param_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] d;
  logic       lv;
  logic       sr;
  logic       l_lr, l_qs, l_qv, l_ql, l_dn;
  logic       m_lr, m_qs, m_qv, m_ql, m_dn;
  logic [0:0] one_d;
  logic       one_lv, one_sr;
  logic       o_lr, o_qs, o_qv, o_ql, o_dn;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0] d;
    logic [3:0] exp_lsb;  // bit k = k-th emitted bit
    logic [3:0] exp_msb;
  } vec_t;

  vec_t vecs [5];

  always #5 clk = ~clk;

  param_serializer #(.N(4), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .d_param(d), .load_valid(lv), .load_ready(l_lr),
    .q_serial(l_qs), .q_valid(l_qv), .ser_ready(sr), .q_last(l_ql), .done(l_dn));

  param_serializer #(.N(4), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst), .d_param(d), .load_valid(lv), .load_ready(m_lr),
    .q_serial(m_qs), .q_valid(m_qv), .ser_ready(sr), .q_last(m_ql), .done(m_dn));

  param_serializer #(.N(1), .MSB_FIRST(0)) u_one (
    .clk(clk), .rst(rst), .d_param(one_d), .load_valid(one_lv), .load_ready(o_lr),
    .q_serial(o_qs), .q_valid(o_qv), .ser_ready(one_sr), .q_last(o_ql), .done(o_dn));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Both N=4 instances share inputs; check one cycle of their outputs.
  task automatic check_both(input string name, input logic qv, input logic ql_l, input logic ql_m,
                            input logic qs_l, input logic qs_m, input logic lr, input logic dn);
    check({name, " lsb q_valid"}, 32'(l_qv), 32'(qv));
    check({name, " msb q_valid"}, 32'(m_qv), 32'(qv));
    check({name, " lsb q_serial"}, 32'(l_qs), 32'(qs_l));
    check({name, " msb q_serial"}, 32'(m_qs), 32'(qs_m));
    check({name, " lsb q_last"}, 32'(l_ql), 32'(ql_l));
    check({name, " msb q_last"}, 32'(m_ql), 32'(ql_m));
    check({name, " lsb load_ready"}, 32'(l_lr), 32'(lr));
    check({name, " msb load_ready"}, 32'(m_lr), 32'(lr));
    check({name, " lsb done"}, 32'(l_dn), 32'(dn));
    check({name, " msb done"}, 32'(m_dn), 32'(dn));
  endtask

  // Load a word with ser_ready held high and check every following cycle.
  task automatic run_word(input string name, input logic [3:0] wd,
                          input logic [3:0] el, input logic [3:0] em);
    d = wd; lv = 1'b1; sr = 1'b1;
    tick();
    lv = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check_both($sformatf("%s bit%0d", name, k), 1'b1, (k == 3), (k == 3),
                 el[k], em[k], 1'b0, 1'b0);
      tick();
    end
    check_both({name, " done"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    check_both({name, " after"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [3:0] pat;
    logic [3:0] got_l, got_m;
    int nb_l, nb_m, nd_l, nd_m;

    vecs[0] = '{d: 4'b1011, exp_lsb: 4'b1011, exp_msb: 4'b1101};
    vecs[1] = '{d: 4'b0110, exp_lsb: 4'b0110, exp_msb: 4'b0110};
    vecs[2] = '{d: 4'b0001, exp_lsb: 4'b0001, exp_msb: 4'b1000};
    vecs[3] = '{d: 4'b1100, exp_lsb: 4'b1100, exp_msb: 4'b0011};
    vecs[4] = '{d: 4'b1001, exp_lsb: 4'b1001, exp_msb: 4'b1001};

    rst = 1'b1; d = 4'b0000; lv = 1'b0; sr = 1'b1;
    one_d = 1'b0; one_lv = 1'b0; one_sr = 1'b1;

    // Reset state.
    tick(); tick();
    check_both("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset one load_ready", 32'(o_lr), 32'd0);
    rst = 1'b0;
    tick();
    check_both("post-reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Table of full words at full throughput.
    for (int i = 0; i < 5; i++) begin
      run_word($sformatf("vec%0d", i), vecs[i].d, vecs[i].exp_lsb, vecs[i].exp_msb);
    end

    // Backpressure: ser_ready low for 3 cycles after the first transfer.
    d = 4'b0110; lv = 1'b1; sr = 1'b1;
    tick();
    lv = 1'b0;
    got_l = 4'b0000; got_m = 4'b0000;
    nb_l = 0; nb_m = 0; nd_l = 0; nd_m = 0;
    for (int c = 0; c < 14; c++) begin
      sr = (c >= 1 && c <= 3) ? 1'b0 : 1'b1;
      if (c >= 2 && c <= 4) begin
        check($sformatf("bp hold lsb q_serial c%0d", c), 32'(l_qs), 32'd1);
        check($sformatf("bp hold lsb q_last c%0d", c), 32'(l_ql), 32'd0);
      end
      if (l_qv && sr && nb_l < 4) begin got_l[nb_l] = l_qs; nb_l++; end
      else if (l_qv && sr) nb_l++;
      if (m_qv && sr && nb_m < 4) begin got_m[nb_m] = m_qs; nb_m++; end
      else if (m_qv && sr) nb_m++;
      if (l_dn) nd_l++;
      if (m_dn) nd_m++;
      tick();
    end
    check("bp lsb bits", 32'(got_l), 32'(4'b0110));
    check("bp msb bits", 32'(got_m), 32'(4'b0110));
    check("bp lsb count", 32'(nb_l), 32'd4);
    check("bp msb count", 32'(nb_m), 32'd4);
    check("bp lsb done count", 32'(nd_l), 32'd1);
    check("bp msb done count", 32'(nd_m), 32'd1);

    // Load while busy: 4'b1111 offered throughout SHIFT must not intrude.
    d = 4'b1001; lv = 1'b1; sr = 1'b1;
    tick();
    d = 4'b1111;
    pat = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      check_both($sformatf("busy bit%0d", k), 1'b1, (k == 3), (k == 3),
                 pat[k], pat[3-k], 1'b0, 1'b0);
      tick();
    end
    check_both("busy done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    lv = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check_both($sformatf("busy second bit%0d", k), 1'b1, (k == 3), (k == 3),
                 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
    end
    check_both("busy second done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();

    // Reset mid-word after two transfers.
    d = 4'b1011; lv = 1'b1; sr = 1'b1;
    tick();
    lv = 1'b0;
    tick(); tick();
    check_both("pre-abort", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    check_both("abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    check_both("abort release", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_word("fresh", 4'b1001, 4'b1001, 4'b1001);

    // N=1 edge width.
    one_d = 1'b1; one_lv = 1'b1;
    tick();
    one_lv = 1'b0;
    check("n1 q_valid", 32'(o_qv), 32'd1);
    check("n1 q_serial", 32'(o_qs), 32'd1);
    check("n1 q_last", 32'(o_ql), 32'd1);
    check("n1 load_ready busy", 32'(o_lr), 32'd0);
    tick();
    check("n1 done", 32'(o_dn), 32'd1);
    check("n1 load_ready at done", 32'(o_lr), 32'd1);
    check("n1 q_valid at done", 32'(o_qv), 32'd0);
    one_d = 1'b0; one_lv = 1'b1;
    tick();
    one_lv = 1'b0;
    check("n1 zero q_valid", 32'(o_qv), 32'd1);
    check("n1 zero q_serial", 32'(o_qs), 32'd0);
    check("n1 zero q_last", 32'(o_ql), 32'd1);
    tick();
    check("n1 zero done", 32'(o_dn), 32'd1);
    tick();
    check("n1 done cleared", 32'(o_dn), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
